// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative RV32M/RV64M multiply/divide unit for the EX stage
module mdu_iter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  logic [2:0]        op;
  logic              neg_q;     // negate product / quotient at the end
  logic              neg_r;     // negate remainder at the end
  logic [XLEN-1:0]   opb;       // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc;       // {hi, lo}: product accumulator or {rem, quot}
  logic [CNT_W-1:0]  count;

  logic              accept;
  logic              a_signed, b_signed, neg_a, neg_b;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   fast_res;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     diff;
  logic [2*XLEN-1:0] acc_nxt;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem;
  logic [XLEN-1:0]   fin_res;

  // Operand decode at accept: signedness, magnitudes and divide fast-path detection
  always_comb begin
    accept   = start && (state == S_IDLE || state == S_DONE);
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    neg_a    = a_signed & rs1[XLEN-1];
    neg_b    = b_signed & rs2[XLEN-1];
    abs_a    = neg_a ? -rs1 : rs1;
    abs_b    = neg_b ? -rs2 : rs2;
    div_zero = funct3[2] && (rs2 == '0);
    div_ovf  = funct3[2] && !funct3[0] && (rs1 == MOST_NEG) && (&rs2);
    if (div_zero) fast_res = funct3[1] ? rs1 : '1;
    else          fast_res = funct3[1] ? '0 : MOST_NEG;
  end

  // One shift-add or restoring-divide step, plus the sign-fixed final result
  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    rem_sh  = acc[2*XLEN-1:XLEN-1];
    diff    = rem_sh - {1'b0, opb};
    if (op[2]) begin
      if (diff[XLEN]) acc_nxt = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else            acc_nxt = {diff[XLEN-1:0],   acc[XLEN-2:0], 1'b1};
    end else begin
      acc_nxt = {mul_sum, acc[XLEN-1:1]};
    end
    prod = neg_q ? -acc_nxt : acc_nxt;
    quot = acc_nxt[XLEN-1:0];
    rem  = acc_nxt[2*XLEN-1:XLEN];
    case (op)
      3'b000:         fin_res = prod[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:         fin_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101: fin_res = neg_q ? -quot : quot;
      default:        fin_res = neg_r ? -rem : rem;
    endcase
  end

  // Control FSM and datapath registers; reset beats flush beats start
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      count  <= '0;
      op     <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opb    <= '0;
      acc    <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (accept) begin
      op    <= funct3;
      neg_q <= neg_a ^ neg_b;
      neg_r <= neg_a;
      count <= '0;
      busy  <= 1'b1;
      if (funct3[2]) begin
        acc <= {{XLEN{1'b0}}, abs_a};
        opb <= abs_b;
      end else begin
        acc <= {{XLEN{1'b0}}, abs_b};
        opb <= abs_a;
      end
      if (div_zero || div_ovf) begin
        state  <= S_DONE;
        done   <= 1'b1;
        result <= fast_res;
      end else begin
        state <= S_CALC;
        done  <= 1'b0;
      end
    end else begin
      case (state)
        S_CALC: begin
          acc   <= acc_nxt;
          count <= count + 1'b1;
          if (count == CNT_W'(XLEN - 1)) begin
            state  <= S_DONE;
            done   <= 1'b1;
            result <= fin_res;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - directed self-checking bench for mdu_iter
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int compared   = 0;
  int mismatched = 0;

  mdu_iter #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one op, wait for done (bounded), check latency, busy span and result.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int n;
    int nb;
    funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    nb = busy ? 1 : 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (busy) nb++;
    end
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " busy cycles"}, 64'(nb), 64'(exp_lat));
    check({tag, " result"}, 64'(result), 64'(exp_res));
    @(posedge clk); #1;
    check({tag, " busy after"}, 64'(busy), 64'd0);
    check({tag, " done after"}, 64'(done), 64'd0);
  endtask

  initial begin
    int m;
    reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'b000; rs1 = '0; rs2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset result", 64'(result), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("mul",    3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mulh",   3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33);
    run_op("mulhsu", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
    run_op("mul_small", 3'b000, 32'd1234, 32'd5678, 32'd7006652, 33);
    run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("divu",   3'b101, 32'd100, 32'd7, 32'd14, 33);
    run_op("div_neg_divisor", 3'b100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);
    run_op("div0",   3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu0",  3'b111, 32'h1234, 32'd0, 32'h1234, 1);
    run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    run_op("remu",   3'b111, 32'd100, 32'd7, 32'd2, 33);

    // Flush at cycle 10 of a DIV, with a start presented alongside it
    funct3 = 3'b100; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("flush pre busy", 64'(busy), 64'd1);
    flush = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    check("flush done", 64'(done), 64'd0);
    check("flush result", 64'(result), 64'd2);
    m = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) m++;
    end
    check("flush no activity", 64'(m), 64'd0);

    // Back-to-back: start held into DONE launches the second op
    funct3 = 3'b011; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk); #1;
    funct3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7;
    m = 1;
    while (!done && m < 100) begin
      @(posedge clk); #1;
      m++;
    end
    check("b2b first latency", 64'(m), 64'd33);
    check("b2b first result", 64'(result), 64'hFFFF_FFFE);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b busy held", 64'(busy), 64'd1);
    check("b2b done low", 64'(done), 64'd0);
    m = 1;
    while (!done && m < 100) begin
      @(posedge clk); #1;
      m++;
    end
    check("b2b second gap", 64'(m), 64'd33);
    check("b2b second result", 64'(result), 64'd14);
    @(posedge clk); #1;
    check("b2b busy after", 64'(busy), 64'd0);

    // Reset in the middle of CALC
    funct3 = 3'b000; rs1 = 32'd3; rs2 = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    check("midreset result", 64'(result), 64'd0);
    m = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) m++;
    end
    check("midreset no done", 64'(m), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
